// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-memory loader and future readers/dumpers.
// Holds the memory geometry, the stream byte order and the loader state encoding.
package mips_pkg;

    localparam int IMEM_MAX_INDEX = 32;
    localparam int IMEM_AW        = 5;
    localparam int IMEM_DW        = 32;
    localparam int IMEM_WORD_BYTES = IMEM_DW / 8;

    // First byte of each word on the stream lands in the most significant lane.
    localparam bit IMEM_BIG_ENDIAN = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        BYTES,
        WRITE,
        DONE,
        ERR
    } ld_state_t;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Collects four stream bytes into one instruction word.
// word_valid flags the 4th byte; word_nxt is the completed word in that cycle.
module word_assembler
    import mips_pkg::*;
#(
    parameter int DW = IMEM_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          byte_en,
    input  logic [7:0]    byte_in,
    output logic          word_valid,
    output logic [DW-1:0] word_nxt
);

    logic [1:0]    cnt_q;
    logic [DW-1:0] shreg_q;

    always_comb begin
        if (IMEM_BIG_ENDIAN) begin
            word_nxt = {shreg_q[DW-9:0], byte_in};
        end else begin
            word_nxt = {byte_in, shreg_q[DW-1:8]};
        end
        word_valid = byte_en && (cnt_q == 2'd3);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= 2'd0;
            shreg_q <= '0;
        end else if (clear) begin
            cnt_q   <= 2'd0;
            shreg_q <= '0;
        end else if (byte_en) begin
            // Counter wraps 3 -> 0 so the next word starts cleanly after WRITE.
            cnt_q   <= cnt_q + 2'd1;
            shreg_q <= word_nxt;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream into instruction memory from address 0,
// stalling the CPU for the duration of the session.
module imem_loader
    import mips_pkg::*;
#(
    parameter int MAX_INDEX = IMEM_MAX_INDEX,
    parameter int AW        = IMEM_AW,
    parameter int DW        = IMEM_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          we,
    output logic [AW-1:0] wa,
    output logic [DW-1:0] wd,
    output logic          hold,
    output logic          done,
    output logic          err,
    output logic [AW:0]   words_loaded
);

    ld_state_t     state_q, state_d;
    logic [AW:0]   n_q;
    logic [AW:0]   cnt_q;
    logic [AW-1:0] idx_q;
    logic [DW-1:0] wd_q;

    logic          xfer;
    logic          hdr_byte;
    logic          byte_en;
    logic          begin_session;
    logic          last_word;
    logic          word_valid;
    logic [DW-1:0] word_nxt;

    function automatic logic hdr_valid(input logic [7:0] n);
        return (n != 8'd0) && (int'(n) <= MAX_INDEX);
    endfunction

    always_comb begin
        xfer          = in_valid && in_ready;
        hdr_byte      = xfer && (state_q == HDR);
        byte_en       = xfer && (state_q == BYTES);
        begin_session = start && ((state_q == IDLE) || (state_q == DONE) || (state_q == ERR));
        last_word     = ((cnt_q + 1'b1) == n_q);
    end

    word_assembler #(
        .DW (DW)
    ) u_asm (
        .clk        (clk),
        .reset      (reset),
        .clear      (begin_session),
        .byte_en    (byte_en),
        .byte_in    (in_data),
        .word_valid (word_valid),
        .word_nxt   (word_nxt)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) state_d = HDR;
            end
            HDR: begin
                if (hdr_byte) state_d = hdr_valid(in_data) ? BYTES : ERR;
            end
            BYTES: begin
                if (word_valid) state_d = WRITE;
            end
            WRITE: begin
                state_d = last_word ? DONE : BYTES;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready     = (state_q == HDR) || (state_q == BYTES);
        hold         = (state_q == HDR) || (state_q == BYTES) || (state_q == WRITE);
        we           = (state_q == WRITE);
        done         = (state_q == DONE);
        err          = (state_q == ERR);
        wa           = idx_q;
        wd           = wd_q;
        words_loaded = cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            n_q     <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            if (begin_session) begin
                n_q   <= '0;
                cnt_q <= '0;
                idx_q <= '0;
            end
            if (hdr_byte && hdr_valid(in_data)) begin
                n_q <= in_data[AW:0];
            end
            if (word_valid) begin
                wd_q <= word_nxt;
            end
            if (state_q == WRITE) begin
                cnt_q <= cnt_q + 1'b1;
                // Index stops at N-1 so it never wraps when N == MAX_INDEX.
                if (!last_word) idx_q <= idx_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: byte-stream sessions with hand-computed writes.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        hold;
    logic        done;
    logic        err;
    logic [5:0]  words_loaded;

    int n_checks = 0;
    int n_fail   = 0;

    logic [4:0]  wr_addr[$];
    logic [31:0] wr_data[$];
    int          ready_bad = 0;

    always #5 clk = ~clk;

    imem_loader dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .we           (we),
        .wa           (wa),
        .wd           (wd),
        .hold         (hold),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always @(negedge clk) begin
        if (we) begin
            wr_addr.push_back(wa);
            wr_data.push_back(wd);
            if (in_ready) ready_bad++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int guard;
        guard = 0;
        repeat ($urandom_range(0, max_gap)) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) chk("ready_timeout", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int max_gap);
        send_byte(w[31:24], max_gap);
        send_byte(w[23:16], max_gap);
        send_byte(w[15:8],  max_gap);
        send_byte(w[7:0],   max_gap);
    endtask

    task automatic wait_end();
        int g;
        g = 0;
        while (!(done || err) && g < 2000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 2000) chk("session_timeout", {31'd0, done | err}, 32'd1);
    endtask

    logic [31:0] exp_w[32];
    int          base;

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_we",       {31'd0, we},       32'd0);
        chk("rst_wa",       {27'd0, wa},       32'd0);
        chk("rst_wd",       wd,                32'd0);
        chk("rst_hold",     {31'd0, hold},     32'd0);
        chk("rst_done",     {31'd0, done},     32'd0);
        chk("rst_err",      {31'd0, err},      32'd0);
        chk("rst_words",    {26'd0, words_loaded}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_ready", {31'd0, in_ready}, 32'd0);

        // Three-word program
        pulse_start();
        chk("hdr_hold",  {31'd0, hold},     32'd1);
        chk("hdr_ready", {31'd0, in_ready}, 32'd1);
        send_byte(8'd3, 0);
        send_word(32'h2010000F, 0);
        send_word(32'h20110019, 0);
        send_word(32'h20120014, 0);
        wait_end();
        chk("p3_nwr",   wr_addr.size(), 32'd3);
        chk("p3_wa0",   {27'd0, wr_addr[0]}, 32'd0);
        chk("p3_wd0",   wr_data[0], 32'h2010000F);
        chk("p3_wa1",   {27'd0, wr_addr[1]}, 32'd1);
        chk("p3_wd1",   wr_data[1], 32'h20110019);
        chk("p3_wa2",   {27'd0, wr_addr[2]}, 32'd2);
        chk("p3_wd2",   wr_data[2], 32'h20120014);
        chk("p3_done",  {31'd0, done}, 32'd1);
        chk("p3_err",   {31'd0, err},  32'd0);
        chk("p3_hold",  {31'd0, hold}, 32'd0);
        chk("p3_ready", {31'd0, in_ready}, 32'd0);
        chk("p3_words", {26'd0, words_loaded}, 32'd3);

        // Bad headers: 0 then 33
        base = wr_addr.size();
        pulse_start();
        chk("h0_done_clr", {31'd0, done}, 32'd0);
        send_byte(8'd0, 0);
        wait_end();
        chk("h0_err",  {31'd0, err},  32'd1);
        chk("h0_done", {31'd0, done}, 32'd0);
        chk("h0_hold", {31'd0, hold}, 32'd0);
        chk("h0_nwr",  wr_addr.size(), base);
        pulse_start();
        chk("h0_err_clr", {31'd0, err},  32'd0);
        chk("h0_rehold",  {31'd0, hold}, 32'd1);
        send_byte(8'd33, 0);
        wait_end();
        chk("h33_err",   {31'd0, err},  32'd1);
        chk("h33_hold",  {31'd0, hold}, 32'd0);
        chk("h33_ready", {31'd0, in_ready}, 32'd0);
        chk("h33_nwr",   wr_addr.size(), base);
        chk("h33_words", {26'd0, words_loaded}, 32'd0);

        // Full 32-word load with random source gaps
        pulse_start();
        chk("h32_err_clr", {31'd0, err}, 32'd0);
        base = wr_addr.size();
        for (int i = 0; i < 32; i++) exp_w[i] = $urandom;
        send_byte(8'd32, 2);
        for (int i = 0; i < 32; i++) send_word(exp_w[i], 2);
        wait_end();
        chk("full_nwr", wr_addr.size() - base, 32'd32);
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("full_wa%0d", i), {27'd0, wr_addr[base+i]}, i);
            chk($sformatf("full_wd%0d", i), wr_data[base+i], exp_w[i]);
        end
        chk("full_done",  {31'd0, done}, 32'd1);
        chk("full_err",   {31'd0, err},  32'd0);
        chk("full_words", {26'd0, words_loaded}, 32'd32);
        chk("wr_ready_low", ready_bad, 32'd0);

        // Reset in the middle of the second word
        pulse_start();
        base = wr_addr.size();
        send_byte(8'd2, 0);
        send_word(32'h11223344, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_hold",  {31'd0, hold},     32'd0);
        chk("mid_ready", {31'd0, in_ready}, 32'd0);
        chk("mid_we",    {31'd0, we},       32'd0);
        chk("mid_wa",    {27'd0, wa},       32'd0);
        chk("mid_wd",    wd,                32'd0);
        chk("mid_words", {26'd0, words_loaded}, 32'd0);
        chk("mid_done",  {31'd0, done},     32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_nwr", wr_addr.size() - base, 32'd1);
        chk("mid_wd0", wr_data[base], 32'h11223344);
        pulse_start();
        base = wr_addr.size();
        send_byte(8'd2, 0);
        send_word(32'hCAFEBABE, 0);
        send_word(32'h0BADF00D, 0);
        wait_end();
        chk("re_nwr",   wr_addr.size() - base, 32'd2);
        chk("re_wa0",   {27'd0, wr_addr[base]},   32'd0);
        chk("re_wd0",   wr_data[base],            32'hCAFEBABE);
        chk("re_wa1",   {27'd0, wr_addr[base+1]}, 32'd1);
        chk("re_wd1",   wr_data[base+1],          32'h0BADF00D);
        chk("re_done",  {31'd0, done}, 32'd1);
        chk("re_words", {26'd0, words_loaded}, 32'd2);

        // Single word, stray start in BYTES, bytes offered while DONE
        pulse_start();
        base = wr_addr.size();
        send_byte(8'd1, 0);
        send_byte(8'h00, 0);
        send_byte(8'h11, 0);
        pulse_start();
        chk("st_hold",  {31'd0, hold},     32'd1);
        chk("st_ready", {31'd0, in_ready}, 32'd1);
        send_byte(8'h88, 0);
        send_byte(8'h20, 0);
        @(negedge clk);
        chk("one_we",    {31'd0, we},       32'd1);
        chk("one_wa",    {27'd0, wa},       32'd0);
        chk("one_wd",    wd,                32'h00118820);
        chk("one_ready", {31'd0, in_ready}, 32'd0);
        chk("one_done0", {31'd0, done},     32'd0);
        @(negedge clk);
        chk("one_we_off", {31'd0, we},   32'd0);
        chk("one_done",   {31'd0, done}, 32'd1);
        chk("one_hold",   {31'd0, hold}, 32'd0);
        in_valid = 1'b1;
        in_data  = 8'h55;
        repeat (3) begin
            @(negedge clk);
            chk("dn_ready", {31'd0, in_ready}, 32'd0);
            chk("dn_done",  {31'd0, done},     32'd1);
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("one_nwr",   wr_addr.size() - base, 32'd1);
        chk("one_words", {26'd0, words_loaded}, 32'd1);
        chk("one_wr_ready_low", ready_bad, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
